// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler: FSM state encoding,
// coordinate width and the pixel-count arithmetic width.
package draw_pkg;

  localparam int COORD_W = 16;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WINDOW,
    S_PIXEL,
    S_RELEASE
  } state_t;

  // Inclusive window size; widened before subtracting so a full-width span cannot wrap.
  function automatic logic [CNT_W-1:0] pix_count(input logic [COORD_W-1:0] xs,
                                                 input logic [COORD_W-1:0] xe,
                                                 input logic [COORD_W-1:0] ys,
                                                 input logic [COORD_W-1:0] ye);
    logic [CNT_W-1:0] w;
    logic [CNT_W-1:0] h;
    w = CNT_W'(xe) - CNT_W'(xs) + CNT_W'(1);
    h = CNT_W'(ye) - CNT_W'(ys) + CNT_W'(1);
    return w * h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      ptr,
  output logic            any,
  output logic [3:0]      index
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req[k] && (k == (int'(ptr) + i) % NREQ)) begin
          any   = 1'b1;
          index = 4'(k);
        end
      end
    end
  end

endmodule

// File: rtl/draw_sched.sv
// Shares one LCD window/pixel port among NREQ drawing requesters, one
// transaction at a time, granted round-robin.
module draw_sched
  import draw_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NREQ-1:0]         req_update,
  input  logic [NREQ-1:0]         req_drawdone,
  input  logic [COORD_W*NREQ-1:0] req_xstart,
  input  logic [COORD_W*NREQ-1:0] req_xend,
  input  logic [COORD_W*NREQ-1:0] req_ystart,
  input  logic [COORD_W*NREQ-1:0] req_yend,
  input  logic [COORD_W*NREQ-1:0] req_color,
  output logic [NREQ-1:0]         req_draw,
  output logic [NREQ-1:0]         req_cnext,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [COORD_W-1:0]      win_xs,
  output logic [COORD_W-1:0]      win_xe,
  output logic [COORD_W-1:0]      win_ys,
  output logic [COORD_W-1:0]      win_ye,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [COORD_W-1:0]      pix_color,
  output logic                    busy,
  output logic [3:0]              grant_id,
  output logic                    err_window,
  output logic                    err_timeout,
  output state_t                  dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; while
  // valid is high and ready is low, the payload is held unchanged.

  state_t             state, state_nxt;
  logic [3:0]         rr_ptr;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [CNT_W-1:0]   count;
  logic [31:0]        tmo_cnt;
  logic               arb_any;
  logic [3:0]         arb_idx, grant_nxt;
  logic [COORD_W-1:0] sel_xs, sel_xe, sel_ys, sel_ye, cur_color;
  logic               bad_win, done, tmo_hit, fire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_update),
    .ptr   (rr_ptr),
    .any   (arb_any),
    .index (arb_idx)
  );

  // Candidate slices follow the arbiter; live drawdone/color follow the grant.
  always_comb begin
    sel_xs    = '0;
    sel_xe    = '0;
    sel_ys    = '0;
    sel_ye    = '0;
    cur_color = '0;
    done      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == 4'(i)) begin
        sel_xs = req_xstart[i*COORD_W +: COORD_W];
        sel_xe = req_xend[i*COORD_W +: COORD_W];
        sel_ys = req_ystart[i*COORD_W +: COORD_W];
        sel_ye = req_yend[i*COORD_W +: COORD_W];
      end
      if (grant_id == 4'(i)) begin
        cur_color = req_color[i*COORD_W +: COORD_W];
        done      = req_drawdone[i];
      end
    end
  end

  assign bad_win   = (sel_xe < sel_xs) || (sel_ye < sel_ys);
  assign tmo_hit   = (tmo_cnt == 32'(TIMEOUT - 1));
  assign grant_nxt = (state == S_IDLE) ? arb_idx : grant_id;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (arb_any) state_nxt = bad_win ? S_RELEASE : S_WINDOW;
      S_WINDOW:  if (win_ready) state_nxt = S_PIXEL;
      S_PIXEL:   if (pix_ready && count == CNT_W'(1)) state_nxt = S_RELEASE;
      S_RELEASE: if (done || tmo_hit) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      xs          <= '0;
      xe          <= '0;
      ys          <= '0;
      ye          <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      err_window  <= 1'b0;
      err_timeout <= 1'b0;
      req_draw    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && arb_any) begin
        grant_id   <= arb_idx;
        rr_ptr     <= (arb_idx == 4'(NREQ - 1)) ? 4'd0 : arb_idx + 4'd1;
        xs         <= sel_xs;
        xe         <= sel_xe;
        ys         <= sel_ys;
        ye         <= sel_ye;
        count      <= bad_win ? '0 : pix_count(sel_xs, sel_xe, sel_ys, sel_ye);
        err_window <= err_window | bad_win;
      end
      if (fire) count <= count - CNT_W'(1);
      // Counts completed RELEASE cycles; cleared on any other state.
      tmo_cnt <= (state == S_RELEASE && state_nxt == S_RELEASE) ? tmo_cnt + 32'd1 : 32'd0;
      if (state == S_RELEASE && !done && tmo_hit) err_timeout <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        req_draw[i] <= (state_nxt == S_WINDOW || state_nxt == S_PIXEL) && (grant_nxt == 4'(i));
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign win_valid = (state == S_WINDOW);
  assign win_xs    = win_valid ? xs : '0;
  assign win_xe    = win_valid ? xe : '0;
  assign win_ys    = win_valid ? ys : '0;
  assign win_ye    = win_valid ? ye : '0;
  assign pix_valid = (state == S_PIXEL);
  assign pix_color = pix_valid ? cur_color : '0;
  assign fire      = pix_valid && pix_ready;
  assign dbg_state = state;

  always_comb begin
    req_cnext = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_cnext[i] = fire && (grant_id == 4'(i));
    end
  end

endmodule
